letc_core_fetch_pcgen: RTL

Parametrised successor to the LETC single-word F1 fetch stage. It generates fetch-group PCs of `FETCH_WIDTH` instructions, arbitrates trap/branch redirects, and translates each group through a variable-latency ITLB request/response handshake, with an optional bare-mode bypass. Results go to F2 through a registered valid/ready output, replacing global stall with backpressure. Translation faults are reported per group.

---
 rtl/letc_core_pkg.sv | 40 ++++
 rtl/letc_core_fetch_group_calc.sv | 35 +++
 rtl/letc_core_fetch_pcgen.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/letc_core_pkg.sv
// Shared LETC core types: PC/address widths, reset PC and fetch-stage state/group types.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package letc_core_pkg;

    // PCs are kept as 32-bit-instruction word addresses; byte address = {pc, 2'b00}.
    localparam int PC_WORD_W = 29;
    localparam int WORD_W    = 32;
    localparam int PADDR_W   = 32;

    typedef logic [PC_WORD_W-1:0] pc_word_t;
    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [PADDR_W-1:0]   paddr_t;

    localparam pc_word_t RESET_PC_WORD = '0;

    // Widest fetch group the front end is built for.
    localparam int FETCH_WIDTH_MAX = 4;

    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        WAIT    = 2'd1,
        DRAIN   = 2'd2,
        FAULTED = 2'd3
    } fetch_state_e;

    // Per-group payload handed to F2 (lane mask lives beside it since its
    // width depends on the fetch width).
    typedef struct packed {
        pc_word_t pc_word;
        paddr_t   fetch_addr;
        logic     fault;
    } f2_group_t;

    // Word PC to zero-extended byte address.
    function automatic word_t pc_to_byte_addr(input pc_word_t pc);
        return {{(WORD_W - PC_WORD_W - 2){1'b0}}, pc, 2'b00};
    endfunction

endpackage

// File: rtl/letc_core_fetch_group_calc.sv
// Fetch-group arithmetic: group base, valid-lane mask and next sequential group PC.
// Latency: purely combinational.
// Backpressure: none (no state).
//   i_pc        : current fetch PC (word address)
//   o_base      : i_pc with the low log2(FETCH_WIDTH) bits cleared
//   o_lane_mask : bit i set when lane i is at or after the PC's lane
//   o_next_pc   : o_base + FETCH_WIDTH, wrapping silently at the PC width
module letc_core_fetch_group_calc
    import letc_core_pkg::*;
#(
    parameter int FETCH_WIDTH = 2
) (
    input  pc_word_t               i_pc,
    output pc_word_t               o_base,
    output logic [FETCH_WIDTH-1:0] o_lane_mask,
    output pc_word_t               o_next_pc
);

    // FETCH_WIDTH is a power of two, so FETCH_WIDTH-1 selects the lane bits.
    // Written as a mask rather than a slice so FETCH_WIDTH=1 needs no special case.
    localparam pc_word_t LANE_BITS = pc_word_t'(FETCH_WIDTH - 1);

    pc_word_t lane_off;

    always_comb begin
        lane_off    = i_pc & LANE_BITS;
        o_base      = i_pc & ~LANE_BITS;
        o_next_pc   = o_base + pc_word_t'(FETCH_WIDTH);
        o_lane_mask = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            o_lane_mask[i] = (pc_word_t'(i) >= lane_off);
        end
    end

endmodule

// File: rtl/letc_core_fetch_pcgen.sv
// F1 fetch PC generator: trap/branch redirect, per-group ITLB translation (or bare bypass), registered F2 output.
// Latency: bare 1 cycle per group; translate = ITLB latency L + 1 cycle per group; redirect costs one bubble.
// Backpressure: output register holds until F2 ready; no new group or ITLB request is started without room.
//   Redirect in : i_trap_redirect/i_trap_target (wins), i_branch_taken/i_branch_target
//   ITLB        : o_itlb_req_valid/i_itlb_req_ready/o_itlb_req_vaddr, i_itlb_rsp_valid/_paddr/_fault
//   F2 out      : o_f2_valid/i_f2_ready, o_f2_pc_word, o_f2_fetch_addr, o_f2_lane_mask, o_f2_fault
module letc_core_fetch_pcgen
    import letc_core_pkg::*;
#(
    parameter int       FETCH_WIDTH   = 2,
    parameter pc_word_t RESET_PC_WORD = letc_core_pkg::RESET_PC_WORD
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,

    input  logic                   i_trap_redirect,
    input  pc_word_t               i_trap_target,
    input  logic                   i_branch_taken,
    input  pc_word_t               i_branch_target,

    input  logic                   i_translate_en,

    output logic                   o_itlb_req_valid,
    input  logic                   i_itlb_req_ready,
    output word_t                  o_itlb_req_vaddr,
    input  logic                   i_itlb_rsp_valid,
    input  paddr_t                 i_itlb_rsp_paddr,
    input  logic                   i_itlb_rsp_fault,

    output logic                   o_f2_valid,
    input  logic                   i_f2_ready,
    output pc_word_t               o_f2_pc_word,
    output paddr_t                 o_f2_fetch_addr,
    output logic [FETCH_WIDTH-1:0] o_f2_lane_mask,
    output logic                   o_f2_fault
);

    if (!((FETCH_WIDTH == 1) || (FETCH_WIDTH == 2) || (FETCH_WIDTH == 4))
        || (FETCH_WIDTH > FETCH_WIDTH_MAX)) begin : g_bad_fetch_width
        $error("letc_core_fetch_pcgen: FETCH_WIDTH must be 1, 2 or 4");
    end

    fetch_state_e           state_q,   state_d;
    pc_word_t               pc_q,      pc_d;
    logic                   f2_vld_q,  f2_vld_d;
    f2_group_t              f2_grp_q,  f2_grp_d;
    logic [FETCH_WIDTH-1:0] f2_mask_q, f2_mask_d;

    pc_word_t               grp_base;
    pc_word_t               grp_next_pc;
    logic [FETCH_WIDTH-1:0] grp_lane_mask;

    logic     redirect;
    pc_word_t redirect_target;
    logic     room;
    logic     itlb_req_vld;

    letc_core_fetch_group_calc #(
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_group_calc (
        .i_pc        (pc_q),
        .o_base      (grp_base),
        .o_lane_mask (grp_lane_mask),
        .o_next_pc   (grp_next_pc)
    );

    always_comb begin
        redirect        = i_trap_redirect | i_branch_taken;
        redirect_target = i_trap_redirect ? i_trap_target : i_branch_target;
        // Output register is free if empty or being drained this cycle.
        room            = !f2_vld_q || i_f2_ready;

        state_d      = state_q;
        pc_d         = pc_q;
        f2_vld_d     = f2_vld_q && !i_f2_ready;
        f2_grp_d     = f2_grp_q;
        f2_mask_d    = f2_mask_q;
        itlb_req_vld = 1'b0;

        if (redirect) begin
            // A redirect kills the presented group (a same-cycle F2 handshake
            // still completes) and any translation still in flight.
            pc_d     = redirect_target;
            f2_vld_d = 1'b0;
            unique case (state_q)
                // A response landing in the redirect cycle is simply dropped,
                // so nothing remains outstanding and DRAIN is not needed.
                WAIT, DRAIN: state_d = i_itlb_rsp_valid ? ISSUE : DRAIN;
                default:     state_d = ISSUE;
            endcase
        end else begin
            unique case (state_q)
                ISSUE: begin
                    if (room) begin
                        if (!i_translate_en) begin
                            f2_vld_d            = 1'b1;
                            f2_grp_d.pc_word    = pc_q;
                            f2_grp_d.fetch_addr = paddr_t'(pc_to_byte_addr(grp_base));
                            f2_grp_d.fault      = 1'b0;
                            f2_mask_d           = grp_lane_mask;
                            pc_d                = grp_next_pc;
                        end else begin
                            itlb_req_vld = 1'b1;
                            // pc_q is frozen for the whole of WAIT, so it
                            // serves as the latched group PC of the request.
                            if (i_itlb_req_ready) begin
                                state_d = WAIT;
                            end
                        end
                    end
                end
                WAIT: begin
                    // Room was checked before issuing, and nothing else loads
                    // the output register meanwhile, so it is empty here.
                    if (i_itlb_rsp_valid) begin
                        f2_vld_d            = 1'b1;
                        f2_grp_d.pc_word    = pc_q;
                        f2_grp_d.fetch_addr = i_itlb_rsp_paddr;
                        f2_grp_d.fault      = i_itlb_rsp_fault;
                        f2_mask_d           = grp_lane_mask;
                        if (i_itlb_rsp_fault) begin
                            state_d = FAULTED;
                        end else begin
                            pc_d    = grp_next_pc;
                            state_d = ISSUE;
                        end
                    end
                end
                DRAIN: begin
                    if (i_itlb_rsp_valid) begin
                        state_d = ISSUE;
                    end
                end
                FAULTED: begin
                    // Parked until a redirect; the faulting group drains normally.
                end
                default: begin
                    state_d = ISSUE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ISSUE;
            pc_q      <= RESET_PC_WORD;
            f2_vld_q  <= 1'b0;
            f2_grp_q  <= '0;
            f2_mask_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            f2_vld_q  <= f2_vld_d;
            f2_grp_q  <= f2_grp_d;
            f2_mask_q <= f2_mask_d;
        end
    end

    assign o_itlb_req_valid = itlb_req_vld;
    assign o_itlb_req_vaddr = pc_to_byte_addr(grp_base);

    assign o_f2_valid      = f2_vld_q;
    assign o_f2_pc_word    = f2_grp_q.pc_word;
    assign o_f2_fetch_addr = f2_grp_q.fetch_addr;
    assign o_f2_fault      = f2_grp_q.fault;
    assign o_f2_lane_mask  = f2_mask_q;

endmodule
